// File: rtl/spi_counter_receiver.sv
// SPI mode-0 responder for 14-bit counter frames: oversampled pins, framing check, valid/error strobes.
// Optional MISO echo of the last good value is built when SPI_RX_ECHO_EN is defined.
module spi_counter_receiver #(
    parameter int DATA_WIDTH  = 14,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] o_counter,
    output logic                  o_data_valid,
    output logic                  o_frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_pipe, mosi_pipe, ss_pipe;
    logic                   sclk_hist, ss_hist;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       bit_cnt, cnt_n;
    logic [FRAME_BITS-1:0]  rx_shift, rx_n;
    logic [DATA_WIDTH-1:0]  counter_n;
    logic                   valid_n, err_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_pipe <= '0;
            mosi_pipe <= '0;
            ss_pipe   <= '0;
            sclk_hist <= 1'b0;
            ss_hist   <= 1'b0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss};
            sclk_hist <= sclk_pipe[SYNC_STAGES-1];
            ss_hist   <= ss_pipe[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
    assign ss_s      = ss_pipe[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign ss_rise   = ss_s & ~ss_hist;
    assign ss_fall   = ~ss_s & ss_hist;

`ifdef SPI_RX_ECHO_EN
    logic [FRAME_BITS-1:0] tx_shift, tx_n;
    logic                  miso_q, miso_n;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = bit_cnt;
        rx_n      = rx_shift;
        counter_n = o_counter;
        valid_n   = 1'b0;
        err_n     = 1'b0;
`ifdef SPI_RX_ECHO_EN
        tx_n      = tx_shift;
`endif
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    rx_n    = '0;
`ifdef SPI_RX_ECHO_EN
                    tx_n    = FRAME_BITS'(o_counter);
`endif
                end else if (!ss_s) begin
                    // ss already low without a seen falling edge (e.g. after reset): skip the partial frame
                    state_n = WAIT_HIGH;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_n = {rx_shift[FRAME_BITS-2:0], mosi_s};
                    if (bit_cnt != CNT_W'(FRAME_BITS + 1))
                        cnt_n = bit_cnt + CNT_W'(1);
                end
`ifdef SPI_RX_ECHO_EN
                if (sclk_fall)
                    tx_n = tx_shift << 1;
`endif
                // Evaluated on the already-updated count/shift so a coincident last edge still counts
                if (ss_rise) begin
                    state_n = IDLE;
                    if (cnt_n == CNT_W'(FRAME_BITS) && (rx_n >> DATA_WIDTH) == '0) begin
                        counter_n = rx_n[DATA_WIDTH-1:0];
                        valid_n   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (ss_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
`ifdef SPI_RX_ECHO_EN
        miso_n = (state_n == SHIFT) ? tx_n[FRAME_BITS-1] : 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            o_counter    <= '0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= cnt_n;
            rx_shift     <= rx_n;
            o_counter    <= counter_n;
            o_data_valid <= valid_n;
            o_frame_err  <= err_n;
        end
    end

`ifdef SPI_RX_ECHO_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift <= '0;
            miso_q   <= 1'b0;
        end else begin
            tx_shift <= tx_n;
            miso_q   <= miso_n;
        end
    end

    assign miso = miso_q;
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_counter_receiver.sv
// Directed bench for spi_counter_receiver: frame table plus reset-mid-frame and coincident-edge sequences.
module tb_spi_counter_receiver;

    logic        clk = 1'b0;
    logic        reset_n, sclk, mosi, ss;
    logic        miso;
    logic [13:0] o_counter;
    logic        o_data_valid, o_frame_err;

    always #5 clk = ~clk;

    spi_counter_receiver #(
        .DATA_WIDTH (14),
        .FRAME_BITS (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .ss          (ss),
        .miso        (miso),
        .o_counter   (o_counter),
        .o_data_valid(o_data_valid),
        .o_frame_err (o_frame_err)
    );

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
    logic prev_v = 1'b0, prev_e = 1'b0;

    always @(negedge clk) begin
        if (o_data_valid) valid_cnt++;
        if (o_frame_err) err_cnt++;
        if (o_data_valid && o_frame_err) overlap_cnt++;
        if ((o_data_valid && prev_v) || (o_frame_err && prev_e)) wide_cnt++;
        prev_v = o_data_valid;
        prev_e = o_frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] miso_word;

    task automatic half_period();
        repeat (4) @(negedge clk);
    endtask

    task automatic bit_out(input logic b, input logic raise_ss);
        mosi = b;
        half_period();
        sclk = 1'b1;
        miso_word = {miso_word[14:0], miso};
        if (raise_ss) ss = 1'b1;
        half_period();
        sclk = 1'b0;
    endtask

    task automatic send(input logic [31:0] data, input int n, input logic coincide);
        miso_word = '0;
        ss = 1'b0;
        for (int i = n - 1; i >= 0; i--)
            bit_out(data[i], coincide && (i == 0));
        if (!coincide) begin
            half_period();
            ss = 1'b1;
        end
        mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    function automatic logic [15:0] echo_of(input logic [13:0] v);
`ifdef SPI_RX_ECHO_EN
        return {2'b00, v};
`else
        return 16'h0000 & {2'b00, v};
`endif
    endfunction

    typedef struct {
        logic [31:0] data;
        int          nbits;
        logic        good;
        logic [13:0] exp_cnt;
    } vec_t;

    vec_t        vecs[9];
    logic [13:0] last_good;
    int          v0, e0;
    logic [15:0] d;

    initial begin
        vecs[0] = '{32'h1234,  16, 1'b1, 14'h1234};
        vecs[1] = '{32'h3FFF,  16, 1'b1, 14'h3FFF};
        vecs[2] = '{32'h0000,  16, 1'b1, 14'h0000};
        vecs[3] = '{32'h2AAA,  16, 1'b1, 14'h2AAA};
        vecs[4] = '{32'h5555,  15, 1'b0, 14'h2AAA};
        vecs[5] = '{32'h01234, 17, 1'b0, 14'h2AAA};
        vecs[6] = '{32'hC001,  16, 1'b0, 14'h2AAA};
        vecs[7] = '{32'h0ABC,  16, 1'b1, 14'h0ABC};
        vecs[8] = '{32'h0001,  16, 1'b1, 14'h0001};

        reset_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_counter", 32'(o_counter), 32'h0);
        check("reset_valid", 32'(o_data_valid), 32'h0);
        check("reset_err", 32'(o_frame_err), 32'h0);
        check("reset_miso", 32'(miso), 32'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        last_good = 14'h0;
        for (int k = 0; k < 9; k++) begin
            v0 = valid_cnt; e0 = err_cnt;
            send(vecs[k].data, vecs[k].nbits, 1'b0);
            check($sformatf("vec%0d_valid", k), 32'(valid_cnt - v0), vecs[k].good ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_err", k), 32'(err_cnt - e0), vecs[k].good ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_counter", k), 32'(o_counter), 32'(vecs[k].exp_cnt));
            if (vecs[k].nbits == 16)
                check($sformatf("vec%0d_echo", k), 32'(miso_word), 32'(echo_of(last_good)));
            check($sformatf("vec%0d_miso_idle", k), 32'(miso), 32'h0);
            if (vecs[k].good) last_good = vecs[k].exp_cnt;
        end

        // Reset in the middle of a frame, released while ss is still low
        v0 = valid_cnt; e0 = err_cnt;
        d = 16'h2222;
        miso_word = '0;
        ss = 1'b0;
        for (int i = 15; i >= 8; i--) bit_out(d[i], 1'b0);
        reset_n = 1'b0;
        #1;
        check("midreset_counter", 32'(o_counter), 32'h0);
        check("midreset_valid", 32'(o_data_valid), 32'h0);
        check("midreset_miso", 32'(miso), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 7; i >= 0; i--) bit_out(d[i], 1'b0);
        half_period();
        ss = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
        check("partial_valid", 32'(valid_cnt - v0), 32'd0);
        check("partial_err", 32'(err_cnt - e0), 32'd0);
        check("partial_counter", 32'(o_counter), 32'h0);
        last_good = 14'h0;

        v0 = valid_cnt;
        send(32'h0055, 16, 1'b0);
        check("post_reset_counter", 32'(o_counter), 32'h0055);
        check("post_reset_valid", 32'(valid_cnt - v0), 32'd1);
        check("post_reset_echo", 32'(miso_word), 32'(echo_of(last_good)));
        last_good = 14'h0055;

        // Last sclk rise and ss rise land in the same synchronized cycle
        v0 = valid_cnt; e0 = err_cnt;
        send(32'h0155, 16, 1'b1);
        check("coincide_counter", 32'(o_counter), 32'h0155);
        check("coincide_valid", 32'(valid_cnt - v0), 32'd1);
        check("coincide_err", 32'(err_cnt - e0), 32'd0);

        check("pulse_overlap", 32'(overlap_cnt), 32'd0);
        check("pulse_width", 32'(wide_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_counter_receiver.md
# spi_counter_receiver

SPI mode-0 responder that receives the 14-bit run/stop counter frames sent by the master, checks framing, and presents the received value with a one-cycle valid strobe for the FND display path. It sits inside the slave side, between the SPI pins (sclk, mosi, ss, miso) and the display/counter logic. All SPI inputs are asynchronous to `clk` and are oversampled. Optionally it echoes the last good value back to the master on MISO.

## Interface
- `DATA_WIDTH`, 14: payload bits; frame carries `{(FRAME_BITS-DATA_WIDTH)'b0, value}`.
- `FRAME_BITS`, 16: bits per frame, MSB first.
- `SYNC_STAGES`, 2: synchronizer depth for sclk/mosi/ss (≥2).
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock from master, idle low (mode 0).
- `mosi` in 1: serial data, sampled on sclk rising edge.
- `ss` in 1: frame select, active low.
- `miso` out 1: echo data, changes after sclk falling edge; 0 when ss high.
- `o_counter` out DATA_WIDTH: last correctly framed value.
- `o_data_valid` out 1: one-cycle pulse when `o_counter` updates.
- `o_frame_err` out 1: one-cycle pulse on a rejected frame.

## Operation
- Reset values: `o_counter`=0, `o_data_valid`=0, `o_frame_err`=0, `miso`=0, state IDLE, bit count 0, shift registers 0.
- sclk, mosi, ss each pass through SYNC_STAGES flops plus one history flop; edges detected on synchronized signals only.
- States: IDLE, SHIFT, WAIT_HIGH.
- IDLE: on synchronized ss falling → SHIFT; clear bit count; rx shift = 0; load tx shift with `{pad, o_counter}`.
- SHIFT: each sclk rising → rx shift = `{rx[FRAME_BITS-2:0], mosi_sync}`, bit count +1 (saturates at FRAME_BITS+1). Each sclk falling → tx shift left by one, 0 fill.
- SHIFT, on ss rising → IDLE. Frame is good iff bit count == FRAME_BITS and pad bits are all 0. Good: `o_counter` <= rx[DATA_WIDTH-1:0], `o_data_valid` pulse. Bad (short, long, or nonzero pad): `o_frame_err` pulse; `o_counter` unchanged.
- sclk edge and ss rising detected in the same cycle: sclk edge is applied first, then the frame is evaluated with the updated count.
- WAIT_HIGH: entered from reset if synchronized ss is low. Leaves to IDLE when ss is seen high. A partial frame after reset is never accepted.
- `o_data_valid` and `o_frame_err` are never high in the same cycle.

## Timing
- Supported sclk ≤ clk/8; high and low phases each ≥ 4 clk cycles. Minimum ss-high gap between frames is 4 clk cycles.
- `o_data_valid`/`o_frame_err` assert SYNC_STAGES+1 clk edges after ss rises at the pin (±1 for sampling phase). Each pulse is exactly one cycle wide.
- `o_counter` changes in the same cycle `o_data_valid` is high and holds until the next good frame.
- `miso` is registered. It is valid SYNC_STAGES+1 clk cycles after ss falls (first bit) and SYNC_STAGES+1 clk cycles after each sclk falling edge.
- Reset asserted mid-frame: all outputs go to reset values immediately, with no pulse.

## Configuration
- `SPI_RX_ECHO_EN` defined: tx shift register and MISO echo are built as above. MISO carries the previous good value, MSB first.
- Undefined: no tx logic; `miso` is tied to 0. Receive behaviour is identical.

## Test plan
- Reset, then one frame 16'h1234 at clk/8 → `o_counter`=14'h1234, one `o_data_valid` pulse, `o_frame_err` stays 0.
- Frame 16'h3FFF then 16'h0000 → `o_counter` goes 14'h3FFF then 14'h0000 (wrap boundary), two valid pulses.
- 15-bit frame, 17-bit frame, and frame 16'hC001 (nonzero pad), each separately → one `o_frame_err` pulse per frame, `o_counter` keeps its previous value, no valid pulse.
- With `SPI_RX_ECHO_EN`: send 16'h0ABC, then 16'h0001 → MISO bits during the second frame = 16'h0ABC MSB first. Without the macro, MISO stays 0 throughout.
- Assert reset_n low after 8 bits of 16'h2222, release while ss is still low, finish the frame → no valid, no error, `o_counter`=0. The next full frame 16'h0055 → `o_counter`=14'h0055.
- Last sclk rising edge coincides with ss rising in the same synchronized cycle → frame is accepted with count 16, and `o_counter` holds the correct value.
